dualrail_xor_capture: RTL and testbench
=======================================

# dualrail_xor_capture

- Sequential capture stage directly downstream of the two-input XOR/XNOR gate netlist.
- The netlist drives a complementary pair: one output is XOR of the inputs, the other is XNOR.
- This block synchronizes the pair, waits until it holds a legal dual-rail code for a programmable settle time, and emits each settled value once over a valid/ready channel.
- It also flags persistent illegal codes (both rails equal) as a sticky fault and counts value changes.

## Interface
Parameters:
- SETTLE_CYCLES, 16, consecutive stable cycles required before a code is accepted (≥1)
- FAULT_CYCLES, 4, consecutive illegal-code cycles that trigger fault (≥1)
- CNT_W, 8, width of toggle_count

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  capture enable
- rail_xor  in  1  XOR rail from gate stage
- rail_xnor  in  1  XNOR rail from gate stage
- result_ready  in  1  consumer accepts result this cycle
- result_valid  out  1  result_bit holds a settled value
- result_bit  out  1  decoded XOR value
- fault  out  1  sticky illegal-code fault
- clear_fault  in  1  one-cycle pulse, clears fault
- toggle_count  out  CNT_W  saturating count of emitted value changes

## Operation
- Decode on the sampled rails {rail_xor, rail_xnor}:
  - 10 → bit 1
  - 01 → bit 0
  - 00 or 11 → illegal
- States:
  - IDLE: entered from reset or en=0. Stability counter is held at 0. The "last emitted" memory is marked empty.
  - SETTLE: entered on en=1.
    - The counter increments while the legal code equals the previous cycle's code.
    - The counter reloads to 1 when the legal code changes.
    - The counter resets to 0 on an illegal code.
    - It saturates at SETTLE_CYCLES.
  - FAULT: entered when the illegal-code counter reaches FAULT_CYCLES. fault=1 and no results are emitted.
    - clear_fault moves FAULT → SETTLE with both counters at 0, or → IDLE if en=0.
    - fault deasserts on the next edge.
- Emission: when the counter equals SETTLE_CYCLES, the code differs from the last emitted code (or memory is empty), and the output slot is free:
  - load result_bit and set result_valid
  - update the memory
  - increment toggle_count if memory was non-empty, saturating at all-ones
- Handshake:
  - result_valid is held with stable result_bit until a cycle with result_valid & result_ready.
  - While the slot is full, the settled counter stays saturated; only the latest settled code is emitted once the slot frees. Intermediate codes are dropped.
- Simultaneous accept and new emission in the same cycle: the slot refills and result_valid stays high with the new bit.
- en falling: go to IDLE; a pending result stays valid until accepted.
- Fault while a result is pending: the pending result remains until accepted.
- clear_fault outside FAULT has no effect.
- A legal code resets the illegal-code counter to 0.

## Timing
- Reset values:
  - result_valid=0, result_bit=0, fault=0, toggle_count=0
  - state IDLE, synchronizer flops 0
- Latency: a rail change that is stable at the inputs yields result_valid SETTLE_CYCLES+2 edges later (2 synchronizer stages + settle), provided the slot is free.
- Fault latency: FAULT_CYCLES+2 edges after the illegal code appears at the inputs.
- clear_fault and en are sampled directly (not synchronized).
- Reset mid-operation: all state clears immediately (asynchronous). A pending result is discarded.

## Configuration
- DUALRAIL_SYNC_EN defined: rails pass through a 2-flop synchronizer before decode; latencies as stated.
- DUALRAIL_SYNC_EN undefined: rails are decoded directly from the inputs. Every latency above drops by 2 edges; all other behaviour is identical.

## Test plan
- Reset, en=1, rails=10 held: result_valid=1 with result_bit=1 exactly 18 edges after release (SETTLE_CYCLES=16, sync on); toggle_count=0.
- After accept, rails → 01 held 20 cycles with result_ready=1: one result, bit 0, toggle_count=1; no duplicate emission while rails remain 01.
- Rails glitch 10→01 for 5 cycles→10: no emission of 0; counter reloads each change; no toggle.
- result_ready=0, rails 10→01→10 each settled: only the first result is presented until accept. After accept, no new emission (latest code 10 equals memory); toggle_count unchanged.
- Rails=11 for 4 cycles: fault=1 at edge 6. Rails return to 10: fault stays 1. clear_fault pulse: fault=0 next edge, and emission resumes after 16 stable cycles.
- Assert rst while result_valid=1 mid-settle: all outputs read reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/dualrail_xor_capture_if.sv
// Handshake/bus bundle for the dual-rail XOR capture stage.
// slave: capture stage side; master: gate netlist / consumer side.
interface dualrail_xor_capture_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             rail_xor;
  logic             rail_xnor;
  logic             result_ready;
  logic             clear_fault;
  logic             result_valid;
  logic             result_bit;
  logic             fault;
  logic [CNT_W-1:0] toggle_count;

  modport master (
    output en, rail_xor, rail_xnor,
    output result_ready, clear_fault,
    input  result_valid, result_bit,
    input  fault, toggle_count
  );

  modport slave (
    input  en, rail_xor, rail_xnor,
    input  result_ready, clear_fault,
    output result_valid, result_bit,
    output fault, toggle_count
  );
endinterface

// File: rtl/dualrail_xor_capture.sv
// Dual-rail XOR capture: settle, emit once over valid/ready, sticky fault.
// DUALRAIL_SYNC_EN adds a 2-flop rail synchronizer ahead of decode.
module dualrail_xor_capture #(
  parameter int SETTLE_CYCLES = 16,
  parameter int FAULT_CYCLES  = 4,
  parameter int CNT_W         = 8
) (
  input logic                   clk,
  input logic                   rst,
  dualrail_xor_capture_if.slave bus
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int FW = $clog2(FAULT_CYCLES + 1);
  localparam logic [SW-1:0] SET_MAX = SW'(SETTLE_CYCLES);
  localparam logic [FW-1:0] FLT_MAX = FW'(FAULT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       code;
  logic [1:0]       prev_code;
  logic [SW-1:0]    stab_cnt;
  logic [SW-1:0]    stab_nxt;
  logic [SW-1:0]    stab_calc;
  logic [FW-1:0]    ill_cnt;
  logic [FW-1:0]    ill_nxt;
  logic [FW-1:0]    ill_calc;
  logic             legal;
  logic             active;
  logic             emit;
  logic             slot_free;
  logic             fault_hit;
  logic             mem_ok;
  logic             mem_bit;
  logic             valid_q;
  logic             bit_q;
  logic [CNT_W-1:0] tog_q;

`ifdef DUALRAIL_SYNC_EN
  logic [1:0] sync1;
  logic [1:0] sync2;

  // two-stage synchronizer on the rail pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.rail_xor, bus.rail_xnor};
      sync2 <= sync1;
    end
  end

  assign code = sync2;
`else
  assign code = {bus.rail_xor, bus.rail_xnor};
`endif

  // counters, next state and emission decision
  always_comb begin
    legal     = code[1] ^ code[0];
    stab_calc = '0;
    ill_calc  = '0;
    state_nxt = state;
    stab_nxt  = '0;
    ill_nxt   = '0;
    active    = 1'b0;
    emit      = 1'b0;
    slot_free = !valid_q || bus.result_ready;

    if (legal) begin
      if (code == prev_code)
        stab_calc = (stab_cnt == SET_MAX) ?
                    stab_cnt : stab_cnt + 1'b1;
      else
        stab_calc = SW'(1);
    end else begin
      ill_calc = (ill_cnt == FLT_MAX) ?
                 ill_cnt : ill_cnt + 1'b1;
    end
    fault_hit = (ill_calc == FLT_MAX);

    unique case (state)
      IDLE:    active = bus.en;
      SETTLE: begin
        if (!bus.en) state_nxt = IDLE;
        else         active    = 1'b1;
      end
      FAULT: begin
        if (bus.clear_fault)
          state_nxt = bus.en ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (active) begin
      if (fault_hit) begin
        state_nxt = FAULT;
      end else begin
        state_nxt = SETTLE;
        stab_nxt  = stab_calc;
        ill_nxt   = ill_calc;
        emit      = (stab_calc == SET_MAX) &&
                    (!mem_ok || code[1] != mem_bit) &&
                    slot_free;
      end
    end
  end

  // state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      stab_cnt  <= '0;
      ill_cnt   <= '0;
      prev_code <= '0;
    end else begin
      state     <= state_nxt;
      stab_cnt  <= stab_nxt;
      ill_cnt   <= ill_nxt;
      prev_code <= code;
    end
  end

  // output slot: refill wins over accept in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
    end else if (emit) begin
      valid_q <= 1'b1;
      bit_q   <= code[1];
    end else if (valid_q && bus.result_ready) begin
      valid_q <= 1'b0;
    end
  end

  // last-emitted memory and saturating change counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ok  <= 1'b0;
      mem_bit <= 1'b0;
      tog_q   <= '0;
    end else if (state_nxt == IDLE) begin
      mem_ok  <= 1'b0;
    end else if (emit) begin
      mem_ok  <= 1'b1;
      mem_bit <= code[1];
      if (mem_ok && tog_q != '1)
        tog_q <= tog_q + 1'b1;
    end
  end

  assign bus.result_valid = valid_q;
  assign bus.result_bit   = bit_q;
  assign bus.fault        = (state == FAULT);
  assign bus.toggle_count = tog_q;
endmodule

// File: tb/tb_dualrail_xor_capture.sv
// Bench for dualrail_xor_capture: vector table, corner sequences,
// random traffic against a history-based reference model.
module tb_dualrail_xor_capture;
  localparam int S = 16;
  localparam int F = 4;
  localparam int W = 4;
  localparam int TOGMAX = (1 << W) - 1;
`ifdef DUALRAIL_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int L = S + SYNC;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dualrail_xor_capture_if #(.CNT_W(W)) bus();

  dualrail_xor_capture #(
    .SETTLE_CYCLES(S),
    .FAULT_CYCLES (F),
    .CNT_W        (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: codes seen since counting (re)started
  logic [1:0] m_hist[$];
  logic [1:0] m_p0;
  logic [1:0] m_p1;
  int m_mode;
  bit m_mem_ok;
  bit m_mem;
  bit m_valid;
  bit m_bit;
  int m_tog;

  task automatic model_reset();
    m_hist.delete();
    m_p0 = '0;
    m_p1 = '0;
    m_mode = 0;
    m_mem_ok = 0;
    m_mem = 0;
    m_valid = 0;
    m_bit = 0;
    m_tog = 0;
  endtask

  function automatic bit is_legal(logic [1:0] c);
    return c[1] != c[0];
  endfunction

  function automatic int run_legal();
    int n;
    logic [1:0] last;
    n = 0;
    if (m_hist.size() == 0) return 0;
    last = m_hist[m_hist.size()-1];
    if (!is_legal(last)) return 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] != last) break;
      n++;
    end
    return n;
  endfunction

  function automatic int run_illegal();
    int n;
    n = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (is_legal(m_hist[i])) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_edge();
    logic [1:0] code;
    bit acc;
    bit free;
    bit emit;
    code = {bus.rail_xor, bus.rail_xnor};
    if (SYNC != 0) begin
      code = m_p1;
      m_p1 = m_p0;
      m_p0 = {bus.rail_xor, bus.rail_xnor};
    end
    acc  = m_valid && bus.result_ready;
    free = !m_valid || bus.result_ready;
    emit = 0;
    if (m_mode == 2) begin
      if (bus.clear_fault) begin
        m_hist.delete();
        m_mode = bus.en ? 1 : 0;
        if (!bus.en) m_mem_ok = 0;
      end
    end else if (!bus.en) begin
      m_mode = 0;
      m_hist.delete();
      m_mem_ok = 0;
    end else begin
      m_hist.push_back(code);
      if (m_hist.size() > 64) void'(m_hist.pop_front());
      if (run_illegal() >= F) begin
        m_mode = 2;
        m_hist.delete();
      end else begin
        m_mode = 1;
        if (run_legal() >= S &&
            (!m_mem_ok || code[1] != m_mem) && free)
          emit = 1;
      end
    end
    if (emit) begin
      m_valid = 1;
      m_bit = code[1];
      if (m_mem_ok && m_tog < TOGMAX) m_tog++;
      m_mem = code[1];
      m_mem_ok = 1;
    end else if (acc) begin
      m_valid = 0;
    end
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check_outs(string tag, int v, int b, int f, int t);
    check({tag, "_valid"}, int'(bus.result_valid), v);
    check({tag, "_bit"}, int'(bus.result_bit), b);
    check({tag, "_fault"}, int'(bus.fault), f);
    check({tag, "_tog"}, int'(bus.toggle_count), t);
  endtask

  task automatic drive(bit en, bit [1:0] r, bit rdy, bit clr);
    bus.en = en;
    bus.rail_xor = r[1];
    bus.rail_xnor = r[0];
    bus.result_ready = rdy;
    bus.clear_fault = clr;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outs("model", int'(m_valid), int'(m_bit),
               int'(m_mode == 2), m_tog);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit       en;
    bit [1:0] rails;
    bit       rdy;
    bit       clr;
    int       cyc;
    int       v;
    int       b;
    int       f;
    int       tog;
  } vec_t;

  vec_t vt[$];

  task automatic add(bit en, bit [1:0] r, bit rdy, bit clr, int cyc,
                     int v, int b, int f, int tog);
    vec_t x;
    x.en = en; x.rails = r; x.rdy = rdy; x.clr = clr; x.cyc = cyc;
    x.v = v; x.b = b; x.f = f; x.tog = tog;
    vt.push_back(x);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    model_reset();

    add(1, 2'b10, 0, 0, L-1,     0, 0, 0, 0);
    add(1, 2'b10, 0, 0, 1,       1, 1, 0, 0);
    add(1, 2'b10, 1, 0, 1,       0, 1, 0, 0);
    add(1, 2'b01, 1, 0, L-1,     0, 1, 0, 0);
    add(1, 2'b01, 1, 0, 1,       1, 0, 0, 1);
    add(1, 2'b01, 1, 0, 20,      0, 0, 0, 1);
    add(1, 2'b10, 1, 0, 5,       0, 0, 0, 1);
    add(1, 2'b01, 1, 0, L+4,     0, 0, 0, 1);
    add(1, 2'b10, 0, 0, L,       1, 1, 0, 2);
    add(1, 2'b01, 0, 0, L+2,     1, 1, 0, 2);
    add(1, 2'b10, 0, 0, L+2,     1, 1, 0, 2);
    add(1, 2'b10, 1, 0, 1,       0, 1, 0, 2);
    add(1, 2'b10, 1, 0, L+2,     0, 1, 0, 2);
    add(1, 2'b11, 1, 0, F+SYNC-1, 0, 1, 0, 2);
    add(1, 2'b11, 1, 0, 1,       0, 1, 1, 2);
    add(1, 2'b01, 1, 0, L+4,     0, 1, 1, 2);
    add(1, 2'b01, 1, 1, 1,       0, 1, 0, 2);
    add(1, 2'b01, 1, 0, S-1,     0, 1, 0, 2);
    add(1, 2'b01, 1, 0, 1,       1, 0, 0, 3);
    add(1, 2'b01, 1, 0, 1,       0, 0, 0, 3);
    add(1, 2'b01, 1, 1, 3,       0, 0, 0, 3);
    add(0, 2'b01, 1, 0, 2,       0, 0, 0, 3);
    add(1, 2'b01, 1, 0, S-1,     0, 0, 0, 3);
    add(1, 2'b01, 0, 0, 1,       1, 0, 0, 3);
    add(1, 2'b01, 0, 0, 3,       1, 0, 0, 3);

    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].en, vt[i].rails, vt[i].rdy, vt[i].clr);
      repeat (vt[i].cyc) step();
      check_outs($sformatf("vec%0d", i),
                 vt[i].v, vt[i].b, vt[i].f, vt[i].tog);
    end

    drive(1, 2'b10, 0, 0);
    repeat (5) step();
    rst = 1'b1;
    #1;
    check_outs("rst_async", 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    drive(1, 2'b10, 0, 0);
    repeat (L) step();
    check_outs("sim_first", 1, 1, 0, 0);
    drive(1, 2'b01, 0, 0);
    repeat (L+2) step();
    check_outs("sim_held", 1, 1, 0, 0);
    drive(1, 2'b01, 1, 0);
    step();
    check_outs("sim_refill", 1, 0, 0, 1);
    drive(1, 2'b11, 0, 0);
    repeat (F+SYNC) step();
    check_outs("pend_fault", 1, 0, 1, 1);
    drive(1, 2'b11, 1, 0);
    step();
    check_outs("pend_accept", 0, 0, 1, 1);
    drive(1, 2'b01, 1, 1);
    step();
    check_outs("pend_clear", 0, 0, 0, 1);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, (i % 2 == 0) ? 2'b10 : 2'b01, 1, 0);
      repeat (L+2) step();
      if (i == 5) check("tog_mid", int'(bus.toggle_count), 5);
    end
    check("tog_sat", int'(bus.toggle_count), TOGMAX);

    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      bit [1:0] r;
      bit en_r;
      int dur;
      if ($urandom_range(0, 99) < 12)
        r = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
      else
        r = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      en_r = ($urandom_range(0, 99) >= 5);
      dur = $urandom_range(1, 40);
      for (int c = 0; c < dur; c++) begin
        drive(en_r, r, $urandom_range(0, 3) != 0,
              $urandom_range(0, 29) == 0);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
